// File: rtl/spi_pkg.sv
// Shared types for the SPI transaction sequencer and its FIFOs.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ISSUE,
        WAIT1,
        XFER,
        CAPTURE,
        HOLD
    } state_t;

    typedef struct packed {
        logic        half;
        logic [15:0] data;
    } tx_entry_t;

    // A byte-only transfer returns its received byte in the upper half of
    // the engine's rx word; it is right-aligned before it reaches the host.
    function automatic logic [15:0] rx_word(input logic half, input logic [15:0] rx);
        return half ? {8'h00, rx[15:8]} : rx;
    endfunction

endpackage

// File: rtl/spi_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers and synchronous reset.
module spi_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             pop_ok;
    logic             push_ok;

    // A pop on a full FIFO frees the slot the same cycle, so a write there is kept.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer advance on accepted push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage write; contents need no reset since empty masks the head.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/spi_seq.sv
// SPI burst sequencer: feeds queued words to the shift engine under one chip-select.
//
// state   | meaning
// IDLE    | no burst; busy mirrors the engine's running flag
// SETUP   | cs_n low, counting setup time before the first word
// ISSUE   | pop TX head and pulse m_we (stalls while RX is full)
// WAIT1   | engine running flag not yet valid
// XFER    | waiting for the engine to finish the word
// CAPTURE | push received word into RX, continue or wrap up
// HOLD    | counting hold time, then release cs_n unless held
module spi_seq
    import spi_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_we,
    input  logic [15:0] tx_data,
    input  logic        tx_half,
    output logic        tx_full,
    input  logic        start,
    input  logic        hold_cs,
    input  logic        rx_re,
    output logic [15:0] rx_data,
    output logic        rx_empty,
    output logic        busy,
    output logic        ovf,
    output logic        cs_n,
    output logic        m_we,
    output logic        m_both,
    output logic [15:0] m_tx,
    input  logic [15:0] m_rx,
    input  logic        m_running
);

    localparam logic [7:0] SETUP_LOAD = 8'((CS_SETUP > 0) ? CS_SETUP - 1 : 0);
    localparam logic [7:0] HOLD_LOAD  = 8'((CS_HOLD  > 0) ? CS_HOLD  - 1 : 0);

    state_t    state;
    state_t    state_nx;
    logic [7:0] cnt;
    logic      cs_n_q;
    logic      hold_q;
    logic      half_q;
    logic      ovf_q;
    tx_entry_t tx_head;
    logic      tx_empty;
    logic      rx_full;
    logic      tx_pop;
    logic      rx_push;
    logic      issue;
    logic      start_ok;

    spi_fifo #(.WIDTH(17), .DEPTH(DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (tx_we),
        .wr_data ({tx_half, tx_data}),
        .pop     (tx_pop),
        .rd_data (tx_head),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    spi_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (rx_push),
        .wr_data (rx_word(half_q, m_rx)),
        .pop     (rx_re),
        .rd_data (rx_data),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    assign start_ok = (state == IDLE) && start && !m_running && !tx_empty;
    assign issue    = (state == ISSUE) && !rx_full && !m_running;

    // State register plus setup/hold down-counter, chip-select and latched burst flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            cs_n_q <= 1'b1;
            hold_q <= 1'b0;
            half_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            state <= state_nx;
            // ISSUE pops only a non-empty FIFO, so tx_pop alone frees a full slot.
            if (tx_we && tx_full && !tx_pop) ovf_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        hold_q <= hold_cs;
                        cs_n_q <= 1'b0;
                        cnt    <= SETUP_LOAD;
                    end
                end
                SETUP: begin
                    if (cnt != 8'd0) cnt <= cnt - 8'd1;
                end
                ISSUE: begin
                    if (issue) half_q <= tx_head.half;
                end
                CAPTURE: begin
                    cnt <= HOLD_LOAD;
                end
                HOLD: begin
                    if (cnt != 8'd0) cnt <= cnt - 8'd1;
                    else if (!hold_q) cs_n_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Next-state selection.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                // A previous held burst leaves cs_n low, so setup time is already met.
                if (start_ok) state_nx = (cs_n_q && (CS_SETUP > 0)) ? SETUP : ISSUE;
            end
            SETUP:   if (cnt == 8'd0) state_nx = ISSUE;
            ISSUE:   if (issue) state_nx = WAIT1;
            WAIT1:   state_nx = XFER;
            XFER:    if (!m_running) state_nx = CAPTURE;
            CAPTURE: state_nx = tx_empty ? HOLD : ISSUE;
            HOLD:    if (cnt == 8'd0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Engine strobes, FIFO handshakes and status outputs.
    always_comb begin
        m_we    = issue;
        m_tx    = issue ? tx_head.data : 16'h0000;
        m_both  = issue & ~tx_head.half;
        tx_pop  = issue;
        rx_push = (state == CAPTURE);
        busy    = (state != IDLE) || m_running;
        cs_n    = cs_n_q;
        ovf     = ovf_q;
    end

endmodule

// File: tb/tb_spi_seq.sv
// Bench for spi_seq: two instances (DEPTH 16 and DEPTH 2) each driving a behavioural engine.
module tb_spi_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic        rst     [2];
    logic        tx_we   [2];
    logic [15:0] tx_data [2];
    logic        tx_half [2];
    logic        start   [2];
    logic        hold_cs [2];
    logic        rx_re   [2];
    logic        tx_full [2];
    logic [15:0] rx_data [2];
    logic        rx_empty[2];
    logic        busy    [2];
    logic        ovf     [2];
    logic        cs_n    [2];
    logic        m_we    [2];
    logic        m_both  [2];
    logic [15:0] m_tx    [2];

    logic        eng_run [2] = '{1'b0, 1'b0};
    logic [15:0] eng_rx  [2] = '{16'h0, 16'h0};
    logic [15:0] eng_tx  [2] = '{16'h0, 16'h0};
    int          eng_cnt [2] = '{0, 0};
    logic [15:0] key     [2] = '{16'h0, 16'h0};
    int          fix_lat [2] = '{0, 0};

    int          checks = 0;
    int          errors = 0;
    int          we_cnt      [2] = '{0, 0};
    int          first_we_cyc[2] = '{0, 0};
    int          cs_fall_cyc [2] = '{0, 0};
    int          cs_rise_cnt [2] = '{0, 0};
    logic [15:0] first_tx    [2];
    logic        first_both  [2];
    logic        cs_prev     [2] = '{1'b1, 1'b1};
    int          start_cyc = 0;
    logic [15:0] exp_q[$];

    spi_seq #(.DEPTH(16), .CS_SETUP(2), .CS_HOLD(2)) dut_a (
        .clk(clk), .rst(rst[0]), .tx_we(tx_we[0]), .tx_data(tx_data[0]), .tx_half(tx_half[0]),
        .tx_full(tx_full[0]), .start(start[0]), .hold_cs(hold_cs[0]), .rx_re(rx_re[0]),
        .rx_data(rx_data[0]), .rx_empty(rx_empty[0]), .busy(busy[0]), .ovf(ovf[0]), .cs_n(cs_n[0]),
        .m_we(m_we[0]), .m_both(m_both[0]), .m_tx(m_tx[0]), .m_rx(eng_rx[0]), .m_running(eng_run[0])
    );

    spi_seq #(.DEPTH(2), .CS_SETUP(2), .CS_HOLD(2)) dut_b (
        .clk(clk), .rst(rst[1]), .tx_we(tx_we[1]), .tx_data(tx_data[1]), .tx_half(tx_half[1]),
        .tx_full(tx_full[1]), .start(start[1]), .hold_cs(hold_cs[1]), .rx_re(rx_re[1]),
        .rx_data(rx_data[1]), .rx_empty(rx_empty[1]), .busy(busy[1]), .ovf(ovf[1]), .cs_n(cs_n[1]),
        .m_we(m_we[1]), .m_both(m_both[1]), .m_tx(m_tx[1]), .m_rx(eng_rx[1]), .m_running(eng_run[1])
    );

    // Engine stand-in: runs for 1..5 cycles after m_we, replies tx ^ key. No reset.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (m_we[g]) begin
                eng_run[g] <= 1'b1;
                eng_tx[g]  <= m_tx[g];
                eng_cnt[g] <= (fix_lat[g] != 0) ? fix_lat[g] : int'($urandom_range(4, 0));
            end else if (eng_run[g]) begin
                if (eng_cnt[g] == 0) begin
                    eng_run[g] <= 1'b0;
                    eng_rx[g]  <= eng_tx[g] ^ key[g];
                end else begin
                    eng_cnt[g] <= eng_cnt[g] - 1;
                end
            end
        end
    end

    // Monitor: m_we pulses, chip-select edges, and m_we never during running.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (m_we[g] === 1'b1) begin
                checks++;
                if (eng_run[g] !== 1'b0) begin
                    errors++;
                    $display("FAIL we_while_running inst=%0d got running=%b want 0", g, eng_run[g]);
                end
                if (we_cnt[g] == 0) begin
                    first_we_cyc[g] = cyc;
                    first_tx[g]     = m_tx[g];
                    first_both[g]   = m_both[g];
                end
                we_cnt[g]++;
            end
            if (cs_n[g] === 1'b0 && cs_prev[g] === 1'b1) cs_fall_cyc[g] = cyc;
            if (cs_n[g] === 1'b1 && cs_prev[g] === 1'b0) cs_rise_cnt[g]++;
            cs_prev[g] = cs_n[g];
        end
    end

    task automatic do_rst(input int g);
        @(negedge clk);
        rst[g] = 1'b1;
        @(posedge clk);
        #1 rst[g] = 1'b0;
    endtask

    task automatic push(input int g, input logic [15:0] d, input logic h, input logic track);
        logic [15:0] r;
        @(negedge clk);
        tx_we[g] = 1'b1;
        tx_data[g] = d;
        tx_half[g] = h;
        r = d ^ key[g];
        if (track) exp_q.push_back(h ? {8'h00, r[15:8]} : r);
        @(posedge clk);
        #1 tx_we[g] = 1'b0;
    endtask

    task automatic push_wait(input int g, input logic [15:0] d);
        int n = 0;
        @(negedge clk);
        while (tx_full[g] !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (tx_full[g] !== 1'b0) begin
            errors++;
            $display("FAIL push_wait_timeout inst=%0d tx_full=%b want 0", g, tx_full[g]);
        end
        push(g, d, 1'b0, 1'b1);
    endtask

    task automatic pulse_start(input int g, input logic h);
        @(negedge clk);
        start[g] = 1'b1;
        hold_cs[g] = h;
        start_cyc = cyc;
        @(posedge clk);
        #1 start[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g, input int budget);
        int n = 0;
        @(negedge clk);
        while (busy[g] !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        #1;
        checks++;
        if (busy[g] !== 1'b0) begin
            errors++;
            $display("FAIL idle_timeout inst=%0d busy=%b want 0", g, busy[g]);
        end
    endtask

    task automatic pop_one(input int g);
        logic [15:0] e;
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (rx_empty[g] !== 1'b0 || rx_data[g] !== e) begin
            errors++;
            $display("FAIL rx_word inst=%0d got empty=%b data=%h want empty=0 data=%h",
                     g, rx_empty[g], rx_data[g], e);
        end
        rx_re[g] = 1'b1;
        @(posedge clk);
        #1 rx_re[g] = 1'b0;
    endtask

    task automatic pop_all(input int g);
        while (exp_q.size() > 0) pop_one(g);
        @(negedge clk);
        checks++;
        if (rx_empty[g] !== 1'b1) begin
            errors++;
            $display("FAIL rx_drained inst=%0d rx_empty=%b want 1", g, rx_empty[g]);
        end
    endtask

    task automatic test_reset();
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            checks++;
            if ({cs_n[g], m_we[g], m_both[g], busy[g], ovf[g], tx_full[g], rx_empty[g]} !== 7'b1000001) begin
                errors++;
                $display("FAIL reset_flags inst=%0d got %b want 1000001", g,
                         {cs_n[g], m_we[g], m_both[g], busy[g], ovf[g], tx_full[g], rx_empty[g]});
            end
            checks++;
            if (m_tx[g] !== 16'h0 || rx_data[g] !== 16'h0) begin
                errors++;
                $display("FAIL reset_data inst=%0d m_tx=%h rx_data=%h want 0 0", g, m_tx[g], rx_data[g]);
            end
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;
    endtask

    task automatic test_single();
        fix_lat[0] = 3;
        key[0] = 16'hA55A ^ 16'h1234;
        we_cnt[0] = 0;
        push(0, 16'hA55A, 1'b0, 1'b1);
        pulse_start(0, 1'b0);
        wait_idle(0, 100);
        checks++;
        if (we_cnt[0] != 1 || first_we_cyc[0] - cs_fall_cyc[0] != 2) begin
            errors++;
            $display("FAIL single_timing got we=%0d delay=%0d want we=1 delay=2",
                     we_cnt[0], first_we_cyc[0] - cs_fall_cyc[0]);
        end
        checks++;
        if (first_tx[0] !== 16'hA55A || first_both[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_tx got m_tx=%h both=%b want a55a 1", first_tx[0], first_both[0]);
        end
        checks++;
        if (cs_n[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_cs_release got cs_n=%b want 1", cs_n[0]);
        end
        pop_all(0);
    endtask

    task automatic test_half();
        fix_lat[0] = 2;
        key[0] = 16'h0003 ^ 16'hC7AB;
        we_cnt[0] = 0;
        push(0, 16'h0003, 1'b1, 1'b1);
        pulse_start(0, 1'b0);
        wait_idle(0, 100);
        checks++;
        if (we_cnt[0] != 1 || first_both[0] !== 1'b0 || first_tx[0] !== 16'h0003) begin
            errors++;
            $display("FAIL half_issue got we=%0d both=%b m_tx=%h want 1 0 0003",
                     we_cnt[0], first_both[0], first_tx[0]);
        end
        pop_all(0);
    endtask

    task automatic test_burst4();
        fix_lat[0] = 0;
        key[0] = 16'($urandom);
        we_cnt[0] = 0;
        cs_rise_cnt[0] = 0;
        for (int i = 1; i <= 4; i++) push(0, 16'(i), 1'b0, 1'b1);
        pulse_start(0, 1'b0);
        wait_idle(0, 200);
        checks++;
        if (we_cnt[0] != 4 || cs_rise_cnt[0] != 1) begin
            errors++;
            $display("FAIL burst4 got we=%0d cs_rises=%0d want 4 1", we_cnt[0], cs_rise_cnt[0]);
        end
        pop_all(0);
    endtask

    task automatic test_back_to_back_hold();
        fix_lat[0] = 0;
        key[0] = 16'($urandom);
        we_cnt[0] = 0;
        cs_rise_cnt[0] = 0;
        push(0, 16'h1111, 1'b0, 1'b1);
        push(0, 16'h2222, 1'b0, 1'b1);
        pulse_start(0, 1'b1);
        wait_idle(0, 200);
        repeat (3) @(negedge clk);
        checks++;
        if (cs_n[0] !== 1'b0 || we_cnt[0] != 2) begin
            errors++;
            $display("FAIL hold_first got cs_n=%b we=%0d want 0 2", cs_n[0], we_cnt[0]);
        end
        we_cnt[0] = 0;
        push(0, 16'h3333, 1'b0, 1'b1);
        pulse_start(0, 1'b0);
        wait_idle(0, 200);
        checks++;
        if (we_cnt[0] != 1 || first_we_cyc[0] - start_cyc != 1) begin
            errors++;
            $display("FAIL hold_no_setup got we=%0d delay=%0d want 1 1", we_cnt[0], first_we_cyc[0] - start_cyc);
        end
        checks++;
        if (cs_n[0] !== 1'b1 || cs_rise_cnt[0] != 1) begin
            errors++;
            $display("FAIL hold_release got cs_n=%b rises=%0d want 1 1", cs_n[0], cs_rise_cnt[0]);
        end
        pop_all(0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int n;
            n = int'($urandom_range(10, 1));
            fix_lat[0] = 0;
            key[0] = 16'($urandom);
            we_cnt[0] = 0;
            for (int i = 0; i < n; i++) push(0, 16'($urandom), 1'($urandom), 1'b1);
            pulse_start(0, 1'b0);
            wait_idle(0, 400);
            checks++;
            if (we_cnt[0] != n) begin
                errors++;
                $display("FAIL random_count it=%0d got we=%0d want %0d", it, we_cnt[0], n);
            end
            pop_all(0);
        end
    endtask

    task automatic test_backpressure();
        fix_lat[1] = 0;
        key[1] = 16'($urandom);
        we_cnt[1] = 0;
        push(1, 16'hBEE1, 1'b0, 1'b1);
        push(1, 16'hBEE2, 1'b0, 1'b1);
        pulse_start(1, 1'b0);
        push_wait(1, 16'hBEE3);
        repeat (40) @(negedge clk);
        #1;
        checks++;
        if (we_cnt[1] != 2 || cs_n[1] !== 1'b0 || busy[1] !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall got we=%0d cs_n=%b busy=%b want 2 0 1", we_cnt[1], cs_n[1], busy[1]);
        end
        pop_one(1);
        wait_idle(1, 200);
        checks++;
        if (we_cnt[1] != 3) begin
            errors++;
            $display("FAIL bp_release got we=%0d want 3", we_cnt[1]);
        end
        pop_all(1);
    endtask

    task automatic test_ovf();
        do_rst(0);
        for (int i = 0; i < 16; i++) push(0, 16'(i), 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (tx_full[0] !== 1'b1 || ovf[0] !== 1'b0) begin
            errors++;
            $display("FAIL ovf_at_16 got full=%b ovf=%b want 1 0", tx_full[0], ovf[0]);
        end
        push(0, 16'hFFFF, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (tx_full[0] !== 1'b1 || ovf[0] !== 1'b1) begin
            errors++;
            $display("FAIL ovf_at_17 got full=%b ovf=%b want 1 1", tx_full[0], ovf[0]);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do_rst(0);
        fix_lat[0] = 30;
        push(0, 16'h5A5A, 1'b0, 1'b0);
        pulse_start(0, 1'b0);
        while (eng_run[0] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (eng_run[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_engine_start running=%b want 1", eng_run[0]);
        end
        do_rst(0);
        @(negedge clk);
        checks++;
        if (cs_n[0] !== 1'b1 || rx_empty[0] !== 1'b1 || tx_full[0] !== 1'b0 || busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset got cs_n=%b rx_empty=%b tx_full=%b busy=%b want 1 1 0 1",
                     cs_n[0], rx_empty[0], tx_full[0], busy[0]);
        end
        we_cnt[0] = 0;
        push(0, 16'h7777, 1'b0, 1'b0);
        pulse_start(0, 1'b0);
        n = 0;
        while (eng_run[0] === 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (we_cnt[0] != 0 || busy[0] !== 1'b0 || cs_n[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_start_ignored got we=%0d busy=%b cs_n=%b want 0 0 1", we_cnt[0], busy[0], cs_n[0]);
        end
        fix_lat[0] = 0;
        do_rst(0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int g = 0; g < 2; g++) begin
            rst[g] = 1'b1;
            tx_we[g] = 1'b0;
            tx_data[g] = 16'h0;
            tx_half[g] = 1'b0;
            start[g] = 1'b0;
            hold_cs[g] = 1'b0;
            rx_re[g] = 1'b0;
        end
        test_reset();
        test_single();
        test_half();
        test_burst4();
        test_back_to_back_hold();
        test_random();
        test_backpressure();
        test_ovf();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
